// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command-side driver: op encoding,
// data/register geometry and the driver's FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_N  = 4;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b011;
    localparam logic [2:0] OP_SHR  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_driver_if.sv
// Bus bundle between host, ALU and alu_driver.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid must not depend on ready, and payload is held stable while valid
// is high and ready is low.
interface alu_driver_if;
    import alu_pkg::*;

    // command channel (host -> driver)
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_rd;
    logic [1:0]  cmd_rs1;
    logic [1:0]  cmd_rs2;
    logic        cmd_use_imm;
    logic [15:0] cmd_imm;

    // ALU side (driver -> ALU, ALU -> driver)
    logic        alu_en;
    logic [2:0]  alu_select;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic [15:0] alu_ans;

    // response channel (driver -> host)
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;

    // status / observability
    logic [15:0] op_count;
    state_t      dbg_state;

    // driver view
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
        input  alu_ans, rsp_ready,
        output cmd_ready, alu_en, alu_select, alu_src1, alu_src2,
        output rsp_valid, rsp_data, op_count, dbg_state
    );

    // host + ALU view
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_use_imm, cmd_imm,
        output alu_ans, rsp_ready,
        input  cmd_ready, alu_en, alu_select, alu_src1, alu_src2,
        input  rsp_valid, rsp_data, op_count, dbg_state
    );

endinterface

// File: rtl/regfile4x16.sv
// 4x16 register file: two asynchronous read ports, one synchronous write
// port, asynchronous clear to zero. All four registers are writable.
module regfile4x16
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [1:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_raddr1,
    input  logic [1:0]        i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_regs [REG_N];

    // write port with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_regs[i_raddr1];
    assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/alu_driver.sv
// Command-side initiator for the 16-bit combinational ALU. Accepts one
// micro-op at a time, reads operands from the register file, drives the ALU
// for a single cycle, writes the answer back and returns it to the host.
module alu_driver
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    alu_driver_if.slave bus
);

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_op;
    logic [1:0]        r_rd;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_op_count;

    logic              w_cmd_ready;
    logic              w_rsp_valid;
    logic              w_cmd_fire;
    logic              w_rsp_fire;
    logic              w_we;
    logic              w_alu_en;
    logic [2:0]        w_alu_select;
    logic [DATA_W-1:0] w_alu_src1;
    logic [DATA_W-1:0] w_alu_src2;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    // operand source; writes land before the next command can be accepted,
    // so back-to-back commands always see the updated value
    regfile4x16 u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_we),
        .i_waddr  (r_rd),
        .i_wdata  (w_wdata),
        .i_raddr1 (bus.cmd_rs1),
        .i_raddr2 (bus.cmd_rs2),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and outputs; ALU pins are zero unless an ALU op is issuing
    always_comb begin
        w_next       = r_state;
        w_cmd_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_cmd_fire   = 1'b0;
        w_rsp_fire   = 1'b0;
        w_we         = 1'b0;
        w_alu_en     = 1'b0;
        w_alu_select = 3'b000;
        w_alu_src1   = '0;
        w_alu_src2   = '0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_cmd_fire = 1'b1;
                    w_next     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_we   = 1'b1;
                w_next = ST_RESP;
                if (r_op != OP_LOAD) begin
                    w_alu_en     = 1'b1;
                    w_alu_select = r_op;
                    w_alu_src1   = r_src1;
                    w_alu_src2   = r_src2;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_rsp_fire = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // LOAD bypasses the ALU; otherwise take the ALU answer during ISSUE
    assign w_wdata = (r_op == OP_LOAD) ? r_imm : bus.alu_ans;

    // command latches, captured on the command handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= OP_NOT;
            r_rd   <= 2'd0;
            r_src1 <= '0;
            r_src2 <= '0;
            r_imm  <= '0;
        end else if (w_cmd_fire) begin
            r_op   <= bus.cmd_op;
            r_rd   <= bus.cmd_rd;
            r_src1 <= w_rdata1;
            r_src2 <= bus.cmd_use_imm ? bus.cmd_imm : w_rdata2;
            r_imm  <= bus.cmd_imm;
        end
    end

    // response register, loaded alongside the register-file write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_data <= '0;
        end else if (w_we) begin
            r_rsp_data <= w_wdata;
        end
    end

    // completed-op counter, free-running wrap at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_rsp_fire) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.op_count   = r_op_count;
    assign bus.alu_en     = w_alu_en;
    assign bus.alu_select = w_alu_select;
    assign bus.alu_src1   = w_alu_src1;
    assign bus.alu_src2   = w_alu_src2;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: directed sequence plus a short random burst, with a
// behavioural ALU on the bus and a scoreboard of expected responses.
module tb_alu_driver;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_driver_if bus ();

    alu_driver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q [$];
    logic [15:0] m_regs [4];
    logic [15:0] exp_count = 16'd0;

    // reference ALU behaviour
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SHL:  r = a << b;
            OP_SHR:  r = a >> b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // ALU on the bus: combinational when enabled, holds last answer otherwise
    logic [15:0] alu_hold = 16'h0000;
    always @(posedge clk) if (bus.alu_en) alu_hold <= alu_fn(bus.alu_select, bus.alu_src1, bus.alu_src2);
    assign bus.alu_ans = bus.alu_en ? alu_fn(bus.alu_select, bus.alu_src1, bus.alu_src2) : alu_hold;

    // record ALU activity sampled on the falling edge
    int          en_cycles = 0;
    logic [2:0]  en_sel    = 3'b000;
    always @(negedge clk) begin
        if (bus.alu_en) begin
            en_cycles <= en_cycles + 1;
            en_sel    <= bus.alu_select;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0000;
        exp_q.delete();
        exp_count = 16'd0;
    endtask

    // drive a command's fields, update the model and push the expected result
    task automatic push_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic use_imm, input logic [15:0] imm);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        a   = m_regs[rs1];
        b   = use_imm ? imm : m_regs[rs2];
        res = (op == OP_LOAD) ? imm : alu_fn(op, a, b);
        m_regs[rd] = res;
        exp_q.push_back(res);
        bus.cmd_op      = op;
        bus.cmd_rd      = rd;
        bus.cmd_rs1     = rs1;
        bus.cmd_rs2     = rs2;
        bus.cmd_use_imm = use_imm;
        bus.cmd_imm     = imm;
        bus.cmd_valid   = 1'b1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                            input logic [1:0] rs2, input logic use_imm, input logic [15:0] imm);
        int n;
        @(negedge clk);
        push_cmd(op, rd, rs1, rs2, use_imm, imm);
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    // wait for the response, compare it against the scoreboard, handshake
    task automatic get_rsp(input string tag);
        int n;
        logic [15:0] exp;
        @(negedge clk);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        if (bus.rsp_valid && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, "_rsp_data"}, bus.rsp_data, exp);
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
            exp_count = exp_count + 16'd1;
            @(negedge clk);
            check({tag, "_op_count"}, bus.op_count, exp_count);
            check({tag, "_back_idle"}, bus.cmd_ready, 1'b1);
        end
    endtask

    initial begin
        int e0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = 3'b000;
        bus.cmd_rd      = 2'd0;
        bus.cmd_rs1     = 2'd0;
        bus.cmd_rs2     = 2'd0;
        bus.cmd_use_imm = 1'b0;
        bus.cmd_imm     = 16'h0000;
        bus.rsp_ready   = 1'b0;
        reset_model();

        // reset values
        #2 rst = 1'b1;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 16'h0000);
        check("rst_op_count", bus.op_count, 16'h0000);
        check("rst_alu_pins", {bus.alu_en, bus.alu_select, bus.alu_src1, bus.alu_src2}, 36'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // LOADs then ADD with latency and single-cycle ALU enable checks
        send_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 1'b1, 16'h1234);
        get_rsp("load_r1");
        send_cmd(OP_LOAD, 2'd2, 2'd0, 2'd0, 1'b1, 16'h00F0);
        get_rsp("load_r2");
        check("load_no_alu", en_cycles, 0);
        e0 = en_cycles;
        send_cmd(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 16'h0000);
        @(negedge clk);
        check("add_issue_state", 32'(bus.dbg_state), 32'(ST_ISSUE));
        check("add_alu_en", bus.alu_en, 1'b1);
        check("add_alu_select", bus.alu_select, OP_ADD);
        check("add_alu_srcs", {bus.alu_src1, bus.alu_src2}, {16'h1234, 16'h00F0});
        check("add_rsp_valid_in_issue", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1 check("add_rsp_valid_e1", bus.rsp_valid, 1'b1);
        check("add_const", bus.rsp_data, 16'h1324);
        get_rsp("add");
        check("add_en_one_cycle", en_cycles - e0, 1);
        check("add_en_sel", en_sel, OP_ADD);
        check("add_r3", dut.u_regfile.r_regs[3], 16'h1324);

        // SUB wrap, NOT, shifts
        send_cmd(OP_SUB, 2'd0, 2'd2, 2'd1, 1'b0, 16'h0000);
        @(posedge clk);
        #1 check("sub_const", bus.rsp_data, 16'hEEBC);
        get_rsp("sub");
        send_cmd(OP_NOT, 2'd0, 2'd1, 2'd3, 1'b0, 16'h0000);
        @(posedge clk);
        #1 check("not_const", bus.rsp_data, 16'hEDCB);
        get_rsp("not");
        send_cmd(OP_SHL, 2'd3, 2'd1, 2'd0, 1'b1, 16'd4);
        @(posedge clk);
        #1 check("shl_const", bus.rsp_data, 16'h2340);
        get_rsp("shl");
        send_cmd(OP_SHR, 2'd3, 2'd1, 2'd0, 1'b1, 16'd16);
        @(posedge clk);
        #1 check("shr16_const", bus.rsp_data, 16'h0000);
        get_rsp("shr16");

        // back-to-back rd==rs1 reads the freshly written value
        send_cmd(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 16'd1);
        get_rsp("chain1");
        send_cmd(OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 16'd1);
        get_rsp("chain2");
        check("chain_r1", dut.u_regfile.r_regs[1], 16'h1236);
        send_cmd(OP_AND, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000);
        get_rsp("and");
        send_cmd(OP_OR, 2'd2, 2'd2, 2'd3, 1'b1, 16'hA005);
        get_rsp("or_imm");

        // backpressure: response held five cycles, second command waits
        @(negedge clk);
        push_cmd(OP_LOAD, 2'd3, 2'd0, 2'd0, 1'b1, 16'h5A5A);
        @(posedge clk);
        #1 push_cmd(OP_OR, 2'd0, 2'd3, 2'd3, 1'b1, 16'h0101);
        @(negedge clk);
        check("bp_issue_cmd_ready", bus.cmd_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check("bp_rsp_data", bus.rsp_data, exp_q[0]);
            check("bp_cmd_ready", bus.cmd_ready, 1'b0);
            check("bp_alu_idle", {bus.alu_en, bus.alu_select, bus.alu_src1}, 20'h0);
        end
        check("bp_rsp_pop", bus.rsp_data, exp_q.pop_front());
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        @(negedge clk);
        check("bp_idle_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("bp_op_count", bus.op_count, exp_count);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_second_issue", 32'(bus.dbg_state), 32'(ST_ISSUE));
        get_rsp("bp_second");

        // random burst
        for (int i = 0; i < 10; i++) begin
            send_cmd(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
            get_rsp("rand");
        end

        // reset during RESP of LOAD R2=0xBEEF
        send_cmd(OP_LOAD, 2'd2, 2'd0, 2'd0, 1'b1, 16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_resp", bus.rsp_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", bus.rsp_valid, 1'b0);
        check("abort_rsp_data", bus.rsp_data, 16'h0000);
        check("abort_cmd_ready", bus.cmd_ready, 1'b1);
        check("abort_op_count", bus.op_count, 16'h0000);
        check("abort_r2", dut.u_regfile.r_regs[2], 16'h0000);
        reset_model();
        @(negedge clk);
        rst = 1'b0;

        // counter wrap with a preloaded count
        force dut.r_op_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_op_count;
        exp_count = 16'hFFFE;
        send_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0001);
        get_rsp("wrap_ffff");
        send_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0002);
        get_rsp("wrap_0000");
        check("wrap_zero", bus.op_count, 16'h0000);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
